// File: rtl/enet_rx_packer_if.sv
// Bus bundle for enet_rx_packer: MAC RX byte stream, FIFO write side and
// frame status handshake.
//   master : the packer (consumes RX stream, drives FIFO/status)
//   slave  : the surroundings (MAC, FIFO, DMA/register side)
// Optional drop counter signals exist only with ENET_RX_DROP_CNT_EN defined.
interface enet_rx_packer_if #(
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned LEN_WIDTH  = 16
);
  logic                  rx_valid;
  logic [7:0]            rx_data;
  logic                  rx_sof;
  logic                  rx_eof;
  logic                  rx_err;
  logic [ADDR_WIDTH-1:0] fifo_data_cnt;
  logic                  fifo_wready;
  logic [31:0]           fifo_wdata;
  logic                  fifo_flush;
  logic                  frame_valid;
  logic [LEN_WIDTH-1:0]  frame_len;
  logic                  frame_ready;
`ifdef ENET_RX_DROP_CNT_EN
  logic [15:0]           drop_cnt;
  logic                  drop_cnt_clr;

  modport master (
    input  rx_valid, rx_data, rx_sof, rx_eof, rx_err, fifo_data_cnt, frame_ready,
           drop_cnt_clr,
    output fifo_wready, fifo_wdata, fifo_flush, frame_valid, frame_len, drop_cnt
  );
  modport slave (
    output rx_valid, rx_data, rx_sof, rx_eof, rx_err, fifo_data_cnt, frame_ready,
           drop_cnt_clr,
    input  fifo_wready, fifo_wdata, fifo_flush, frame_valid, frame_len, drop_cnt
  );
`else
  modport master (
    input  rx_valid, rx_data, rx_sof, rx_eof, rx_err, fifo_data_cnt, frame_ready,
    output fifo_wready, fifo_wdata, fifo_flush, frame_valid, frame_len
  );
  modport slave (
    output rx_valid, rx_data, rx_sof, rx_eof, rx_err, fifo_data_cnt, frame_ready,
    input  fifo_wready, fifo_wdata, fifo_flush, frame_valid, frame_len
  );
`endif
endinterface

// File: rtl/enet_rx_packer.sv
// enet_rx_packer: packs MAC RX bytes little-endian into 32-bit FIFO words,
// flushes the FIFO on bad/oversize/overflowing frames and reports each good
// frame's byte length through a valid/ready status handshake.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : enet_rx_packer_if.master (RX stream in, FIFO write/flush out,
//                frame_valid/frame_len out, frame_ready in)
// Optional: define ENET_RX_DROP_CNT_EN to add the saturating dropped-frame
// counter (bus.drop_cnt) with synchronous clear (bus.drop_cnt_clr).
module enet_rx_packer #(
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned LEN_WIDTH  = 16,
  parameter int unsigned MAX_LEN    = 1522
) (
  input logic              clk,
  input logic              rst_n,
  enet_rx_packer_if.master bus
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] CNT_FULL = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RECV, S_DONE, S_DROP} state_t;

  state_t               r_state, w_state_nxt;
  logic [1:0]           r_idx, w_idx_nxt;
  logic [31:0]          r_word, w_word_nxt;
  logic [LEN_WIDTH-1:0] r_len, w_len_nxt;
  logic                 r_wready, w_wready_nxt;
  logic [31:0]          r_wdata, w_wdata_nxt;
  logic                 r_flush, w_flush_nxt;
  logic                 r_fvalid, w_fvalid_nxt;
  logic [LEN_WIDTH-1:0] r_flen, w_flen_nxt;
  logic                 w_drop;

  logic                 w_busy;
  logic [31:0]          w_packed;
  logic [LEN_WIDTH-1:0] w_len_inc;
  logic                 w_len_over;
  logic                 w_need_wr;
  logic                 w_ovf;
  logic                 w_abort;

  // A new frame may only start once the previous status is consumed and the FIFO drained
  assign w_busy = r_fvalid | (bus.fifo_data_cnt != '0);

  // Accumulator upper bytes are always zero, so OR-ing in the new lane also pads partials
  assign w_packed   = r_word | (32'(bus.rx_data) << {r_idx, 3'b000});
  assign w_len_inc  = (r_len == {LEN_WIDTH{1'b1}}) ? r_len : r_len + LEN_WIDTH'(1);
  assign w_len_over = (32'(r_len) >= MAX_LEN);
  assign w_need_wr  = (r_idx == 2'd3) | bus.rx_eof;
  assign w_ovf      = w_need_wr & (bus.fifo_data_cnt == CNT_FULL);
  assign w_abort    = bus.rx_sof | bus.rx_err | w_len_over | w_ovf;

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_idx    <= '0;
      r_word   <= '0;
      r_len    <= '0;
      r_wready <= 1'b0;
      r_wdata  <= '0;
      r_flush  <= 1'b0;
      r_fvalid <= 1'b0;
      r_flen   <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_idx    <= w_idx_nxt;
      r_word   <= w_word_nxt;
      r_len    <= w_len_nxt;
      r_wready <= w_wready_nxt;
      r_wdata  <= w_wdata_nxt;
      r_flush  <= w_flush_nxt;
      r_fvalid <= w_fvalid_nxt;
      r_flen   <= w_flen_nxt;
    end
  end

  // Next-state and output decode
  always_comb begin
    w_state_nxt  = r_state;
    w_idx_nxt    = r_idx;
    w_word_nxt   = r_word;
    w_len_nxt    = r_len;
    w_wready_nxt = 1'b0;
    w_wdata_nxt  = r_wdata;
    w_flush_nxt  = 1'b0;
    w_fvalid_nxt = r_fvalid & ~bus.frame_ready;
    w_flen_nxt   = r_flen;
    w_drop       = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (bus.rx_valid && bus.rx_sof) begin
          if (w_busy || bus.rx_err) begin
            // Nothing written yet, so discard without flushing
            w_drop      = 1'b1;
            w_state_nxt = bus.rx_eof ? S_IDLE : S_DROP;
          end else if (bus.rx_eof) begin
            w_len_nxt    = LEN_WIDTH'(1);
            w_wready_nxt = 1'b1;
            w_wdata_nxt  = 32'(bus.rx_data);
            w_word_nxt   = '0;
            w_idx_nxt    = '0;
            w_state_nxt  = S_DONE;
          end else begin
            w_len_nxt   = LEN_WIDTH'(1);
            w_word_nxt  = 32'(bus.rx_data);
            w_idx_nxt   = 2'd1;
            w_state_nxt = S_RECV;
          end
        end
      end

      S_RECV: begin
        if (bus.rx_valid) begin
          if (w_abort) begin
            // Flush takes the place of any pending write
            w_flush_nxt = 1'b1;
            w_word_nxt  = '0;
            w_idx_nxt   = '0;
            w_len_nxt   = '0;
            w_drop      = 1'b1;
            w_state_nxt = bus.rx_eof ? S_IDLE : S_DROP;
          end else begin
            w_len_nxt = w_len_inc;
            if (w_need_wr) begin
              w_wready_nxt = 1'b1;
              w_wdata_nxt  = w_packed;
              w_word_nxt   = '0;
              w_idx_nxt    = '0;
            end else begin
              w_word_nxt = w_packed;
              w_idx_nxt  = r_idx + 2'd1;
            end
            if (bus.rx_eof) w_state_nxt = S_DONE;
          end
        end
      end

      S_DONE: begin
        w_fvalid_nxt = 1'b1;
        w_flen_nxt   = r_len;
        w_len_nxt    = '0;
        w_idx_nxt    = '0;
        w_word_nxt   = '0;
        w_state_nxt  = S_IDLE;
        // Status is about to become pending, so a frame starting here is busy-dropped
        if (bus.rx_valid && bus.rx_sof) begin
          w_drop      = 1'b1;
          w_state_nxt = bus.rx_eof ? S_IDLE : S_DROP;
        end
      end

      S_DROP: begin
        if (bus.rx_valid && bus.rx_eof) w_state_nxt = S_IDLE;
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign bus.fifo_wready = r_wready;
  assign bus.fifo_wdata  = r_wdata;
  assign bus.fifo_flush  = r_flush;
  assign bus.frame_valid = r_fvalid;
  assign bus.frame_len   = r_flen;

`ifdef ENET_RX_DROP_CNT_EN
  logic [15:0] r_drop_cnt;

  // Saturating dropped-frame counter; clear wins over increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drop_cnt <= '0;
    end else if (bus.drop_cnt_clr) begin
      r_drop_cnt <= '0;
    end else if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
      r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  assign bus.drop_cnt = r_drop_cnt;
`else
  logic w_unused_drop;
  assign w_unused_drop = w_drop;
`endif

endmodule

// File: tb/tb_enet_rx_packer.sv
// Directed bench for enet_rx_packer with a small FIFO occupancy model
// (ADDR_WIDTH = 4 so the overflow case is reachable with an 80-byte frame).
module tb_enet_rx_packer;
  localparam int unsigned AW = 4;
  localparam int unsigned LW = 16;
  localparam int unsigned ML = 1522;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  enet_rx_packer_if #(.ADDR_WIDTH(AW), .LEN_WIDTH(LW)) bus ();

  enet_rx_packer #(.ADDR_WIDTH(AW), .LEN_WIDTH(LW), .MAX_LEN(ML)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // FIFO occupancy model: reader drains instantly unless stalled; flush empties
  logic          stall = 1'b0;
  logic [AW-1:0] fcnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           fcnt <= '0;
    else if (bus.fifo_flush)              fcnt <= '0;
    else if (bus.fifo_wready && stall)    fcnt <= fcnt + AW'(1);
  end
  assign bus.fifo_data_cnt = fcnt;

  // Output monitor, sampled on the falling edge
  int          n_wr = 0, n_fl = 0, n_fv = 0, n_both = 0;
  logic [31:0] wq[$];
  time         t_fl = 0;
  logic        fv_d = 1'b0;
  always @(negedge clk) begin
    if (bus.fifo_wready) begin wq.push_back(bus.fifo_wdata); n_wr++; end
    if (bus.fifo_flush) begin n_fl++; t_fl = $time; end
    if (bus.fifo_wready && bus.fifo_flush) n_both++;
    if (bus.frame_valid && !fv_d) n_fv++;
    fv_d = bus.frame_valid;
  end

  int n_assert = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [7:0] d, input logic s, input logic e, input logic r);
    bus.rx_valid = 1'b1; bus.rx_data = d; bus.rx_sof = s; bus.rx_eof = e; bus.rx_err = r;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    bus.rx_valid = 1'b0; bus.rx_sof = 1'b0; bus.rx_eof = 1'b0; bus.rx_err = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Byte i = start + step*i; byte number 'mark' (1-based) gets its drive time
  // recorded and, if err_on, carries rx_err
  task automatic send_frame(input int n, input int start, input int step,
                            input int mark, input logic err_on, output time t_mark);
    t_mark = 0;
    for (int i = 0; i < n; i++) begin
      if (i + 1 == mark) t_mark = $time;
      drive(8'(start + step * i), i == 0, i == n - 1, err_on && (i + 1 == mark));
    end
  endtask

  task automatic release_status();
    bus.frame_ready = 1'b1;
    @(negedge clk);
    bus.frame_ready = 1'b0;
  endtask

  int  w0, f0, v0, q0;
  time tm;

  initial begin
    bus.rx_valid = 1'b0; bus.rx_data = '0; bus.rx_sof = 1'b0;
    bus.rx_eof = 1'b0; bus.rx_err = 1'b0; bus.frame_ready = 1'b0;
`ifdef ENET_RX_DROP_CNT_EN
    bus.drop_cnt_clr = 1'b0;
`endif
    repeat (3) @(negedge clk);

    // Reset values
    chk("rst_wready", 64'(bus.fifo_wready), 64'd0);
    chk("rst_wdata",  64'(bus.fifo_wdata),  64'd0);
    chk("rst_flush",  64'(bus.fifo_flush),  64'd0);
    chk("rst_fvalid", 64'(bus.frame_valid), 64'd0);
    chk("rst_flen",   64'(bus.frame_len),   64'd0);
`ifdef ENET_RX_DROP_CNT_EN
    chk("rst_dropcnt", 64'(bus.drop_cnt), 64'd0);
`endif
    rst_n = 1'b1;
    idle(2);

    // 64-byte frame 00..3F
    w0 = n_wr; f0 = n_fl; v0 = n_fv; q0 = wq.size();
    send_frame(64, 0, 1, 0, 1'b0, tm);
    idle(3);
    chk("f64_writes", 64'(n_wr - w0), 64'd16);
    chk("f64_word0",  64'(wq[q0]), 64'h03020100);
    chk("f64_word15", 64'(wq[q0 + 15]), 64'h3F3E3D3C);
    chk("f64_flush",  64'(n_fl - f0), 64'd0);
    chk("f64_fvalid", 64'(bus.frame_valid), 64'd1);
    chk("f64_flen",   64'(bus.frame_len), 64'd64);
    idle(5);
    chk("f64_hold_v", 64'(bus.frame_valid), 64'd1);
    chk("f64_hold_l", 64'(bus.frame_len), 64'd64);
    release_status();
    chk("f64_cleared", 64'(bus.frame_valid), 64'd0);
    chk("f64_onestat", 64'(n_fv - v0), 64'd1);

    // 5-byte frame AA BB CC DD EE
    w0 = n_wr; q0 = wq.size();
    send_frame(5, 'hAA, 'h11, 0, 1'b0, tm);
    idle(3);
    chk("f5_writes", 64'(n_wr - w0), 64'd2);
    chk("f5_word0",  64'(wq[q0]), 64'hDDCCBBAA);
    chk("f5_word1",  64'(wq[q0 + 1]), 64'h000000EE);
    chk("f5_flen",   64'(bus.frame_len), 64'd5);
    release_status();

    // 10-byte frame with rx_err on byte 7
    w0 = n_wr; f0 = n_fl; v0 = n_fv;
    send_frame(10, 'h10, 1, 7, 1'b1, tm);
    idle(3);
    chk("err_flushes", 64'(n_fl - f0), 64'd1);
    chk("err_flush_t", 64'(t_fl - tm), 64'd10);
    chk("err_writes",  64'(n_wr - w0), 64'd1);
    chk("err_fvalid",  64'(n_fv - v0), 64'd0);

    // 1-byte frame proves IDLE after the errored eof
    q0 = wq.size();
    drive(8'h5A, 1'b1, 1'b1, 1'b0);
    idle(3);
    chk("one_word", 64'(wq[q0]), 64'h0000005A);
    chk("one_fv",   64'(bus.frame_valid), 64'd1);
    chk("one_flen", 64'(bus.frame_len), 64'd1);
    release_status();

    // 1600-byte frame against MAX_LEN = 1522
    w0 = n_wr; f0 = n_fl; v0 = n_fv;
    send_frame(1600, 0, 1, 1523, 1'b0, tm);
    idle(3);
    chk("big_flushes", 64'(n_fl - f0), 64'd1);
    chk("big_flush_t", 64'(t_fl - tm), 64'd10);
    chk("big_writes",  64'(n_wr - w0), 64'd380);
    chk("big_fvalid",  64'(n_fv - v0), 64'd0);

    // 80-byte frame with the reader stalled: 15 writes then overflow flush
    stall = 1'b1;
    w0 = n_wr; f0 = n_fl; v0 = n_fv; q0 = wq.size();
    send_frame(80, 0, 1, 64, 1'b0, tm);
    idle(3);
    stall = 1'b0;
    chk("ovf_writes",  64'(n_wr - w0), 64'd15);
    chk("ovf_lastwd",  64'(wq[q0 + 14]), 64'h3B3A3938);
    chk("ovf_flushes", 64'(n_fl - f0), 64'd1);
    chk("ovf_flush_t", 64'(t_fl - tm), 64'd10);
    chk("ovf_fvalid",  64'(n_fv - v0), 64'd0);
    chk("ovf_cnt0",    64'(fcnt), 64'd0);

`ifdef ENET_RX_DROP_CNT_EN
    chk("drop_cnt3", 64'(bus.drop_cnt), 64'd3);
    bus.drop_cnt_clr = 1'b1;
    @(negedge clk);
    bus.drop_cnt_clr = 1'b0;
    chk("drop_clr", 64'(bus.drop_cnt), 64'd0);
`endif

    // Back-to-back frames with frame_ready held low
    w0 = n_wr; f0 = n_fl; q0 = wq.size();
    send_frame(5, 'h20, 1, 0, 1'b0, tm);
    idle(3);
    chk("b2b_word0", 64'(wq[q0]), 64'h23222120);
    chk("b2b_word1", 64'(wq[q0 + 1]), 64'h00000024);
    chk("b2b_fv1",   64'(bus.frame_valid), 64'd1);
    w0 = n_wr;
    send_frame(8, 'h40, 1, 0, 1'b0, tm);
    idle(3);
    chk("b2b_writes",  64'(n_wr - w0), 64'd0);
    chk("b2b_flushes", 64'(n_fl - f0), 64'd0);
    chk("b2b_fv2",     64'(bus.frame_valid), 64'd1);
    chk("b2b_flen",    64'(bus.frame_len), 64'd5);
`ifdef ENET_RX_DROP_CNT_EN
    chk("b2b_dropcnt", 64'(bus.drop_cnt), 64'd1);
`endif
    release_status();
    chk("b2b_cleared", 64'(bus.frame_valid), 64'd0);
    chk("never_both",  64'(n_both), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
